mem_bank_programmer: RTL



---
 rtl/mem_bank_programmer_if.sv | 16 +
 rtl/mem_bank_programmer.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_bank_programmer_if.sv
// Row-word handshake between the bitstream loader (master) and the bank programmer (slave).
// cfg_par exists only when MEM_BANK_PARITY_EN is defined.
`timescale 1ns/1ps
interface mem_bank_programmer_if #(parameter int BL_WIDTH = 8);
  logic [BL_WIDTH-1:0] cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
`ifdef MEM_BANK_PARITY_EN
  logic                cfg_par;
  modport master (output cfg_data, cfg_valid, cfg_par, input cfg_ready);
  modport slave  (input cfg_data, cfg_valid, cfg_par, output cfg_ready);
`else
  modport master (output cfg_data, cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, cfg_valid, output cfg_ready);
`endif
endinterface

// File: rtl/mem_bank_programmer.sv
// Writes WL_WIDTH row words into the memory-bank fabric: drive bl, pulse one wl per row.
// Optional MEM_BANK_PARITY_EN: even-parity check per word, bad rows are not pulsed, sticky err.
`timescale 1ns/1ps
module mem_bank_programmer #(
  parameter int BL_WIDTH = 8,
  parameter int WL_WIDTH = 8,
  parameter int WL_PULSE = 2
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  mem_bank_programmer_if.slave cfg,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_WIDTH-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int RW = $clog2(WL_WIDTH);
  localparam int PW = $clog2(WL_PULSE + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [RW-1:0] row;
  logic [PW-1:0] pcnt;
  logic          skip;
  logic          ready_q;
  logic          xfer;
  logic          par_bad;

  assign cfg.cfg_ready = ready_q;
  assign xfer          = (state == S_LOAD) && ready_q && cfg.cfg_valid;

`ifdef MEM_BANK_PARITY_EN
  assign par_bad = (^cfg.cfg_data) != cfg.cfg_par;

  // err clears only when a new pass is launched
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n)                 err <= 1'b0;
    else if (state == S_IDLE && start) err <= 1'b0;
    else if (xfer && par_bad)          err <= 1'b1;
  end
`else
  assign par_bad = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state   <= S_IDLE;
      row     <= '0;
      pcnt    <= '0;
      skip    <= 1'b0;
      ready_q <= 1'b0;
      bl      <= '0;
      wl      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_LOAD;
          row     <= '0;
          ready_q <= 1'b1;
          busy    <= 1'b1;
        end
        S_LOAD: if (xfer) begin
          bl      <= cfg.cfg_data;
          skip    <= par_bad;
          ready_q <= 1'b0;
          state   <= S_SETUP;
        end
        S_SETUP: begin
          // a word with bad parity keeps its slot in the timeline but never fires
          wl    <= skip ? '0 : (WL_WIDTH'(1) << row);
          pcnt  <= PW'(WL_PULSE - 1);
          state <= S_PULSE;
        end
        S_PULSE: begin
          if (pcnt == '0) begin
            wl    <= '0;
            state <= S_HOLD;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (row == RW'(WL_WIDTH - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            bl    <= '0;
          end else begin
            row     <= row + 1'b1;
            ready_q <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_DONE: if (!start) begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
